// File: rtl/wb_pkg.sv
// Shared types for the multi-lane writeback stage.
// Source-select encoding, lane bundle and register-zero constant.
package wb_pkg;

  localparam int WB_XLEN       = 32;
  localparam int WB_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic                     we;
    logic [WB_REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]       data;
  } wb_lane_t;

  localparam logic [WB_REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_lane_mux.sv
// Per-lane writeback source select.
// Flags the reserved encoding on a lane that actually writes.
module wb_lane_mux
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            en,
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] aluout,
  input  logic [XLEN-1:0] read_data,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] data,
  output logic            rsvd
);

  always_comb begin
    data = aluout;
    rsvd = 1'b0;
    unique case (wb_sel_e'(sel))
      WB_ALU: data = aluout;
      WB_MEM: data = read_data;
      WB_PC4: data = pc_plus4;
      WB_RSVD: begin
        data = aluout;
        rsvd = en;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage_multi.sv
// Multi-lane writeback: WAW pruning, pending regs and
// fixed-priority drain onto the register-file write ports.
module wb_stage_multi
  import wb_pkg::*;
#(
  parameter int NUM_LANES  = 2,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_WPORTS = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES-1:0]            lane_en,
  input  logic [NUM_LANES-1:0]            reg_write,
  input  logic [2*NUM_LANES-1:0]          wb_sel,
  input  logic [NUM_LANES*REG_ADDR_W-1:0] rd_addr,
  input  logic [NUM_LANES*XLEN-1:0]       aluout,
  input  logic [NUM_LANES*XLEN-1:0]       read_data,
  input  logic [NUM_LANES*XLEN-1:0]       pc_plus4,
  output logic [NUM_WPORTS-1:0]           rf_we,
  output logic [NUM_WPORTS*REG_ADDR_W-1:0] rf_waddr,
  output logic [NUM_WPORTS*XLEN-1:0]      rf_wdata,
  output logic                            busy,
  output logic [31:0]                     retire_cnt,
  output logic                            sel_err
);

  localparam int RW = REG_ADDR_W;

  logic [NUM_LANES-1:0] pend_q;
  logic [NUM_LANES-1:0] new_p;
  logic [NUM_LANES-1:0] grant;
  logic [NUM_LANES-1:0] lane_wr;
  logic [NUM_LANES-1:0] rsvd;
  logic [XLEN-1:0]      mux_d [NUM_LANES];
  logic [XLEN-1:0]      data_q [NUM_LANES];
  logic [RW-1:0]        rd_q [NUM_LANES];
  logic                 accept;
  int                   rank;

  assign lane_wr = lane_en & reg_write;
  assign accept  = in_valid & in_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    wb_lane_mux #(.XLEN(XLEN)) u_mux (
      .en        (lane_wr[i]),
      .sel       (wb_sel[2*i +: 2]),
      .aluout    (aluout[i*XLEN +: XLEN]),
      .read_data (read_data[i*XLEN +: XLEN]),
      .pc_plus4  (pc_plus4[i*XLEN +: XLEN]),
      .data      (mux_d[i]),
      .rsvd      (rsvd[i])
    );
  end

  // Only the youngest writer of each rd survives.
  always_comb begin
    new_p = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      new_p[i] = lane_wr[i] &&
        (rd_addr[i*RW +: RW] != RW'(REG_ZERO));
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (new_p[j] &&
            rd_addr[j*RW +: RW] == rd_addr[i*RW +: RW])
          new_p[i] = 1'b0;
      end
    end
  end

  always_comb begin
    grant    = '0;
    rf_we    = '0;
    rf_waddr = '0;
    rf_wdata = '0;
    rank     = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (pend_q[i]) begin
        for (int k = 0; k < NUM_WPORTS; k++) begin
          if (rank == k) begin
            grant[i]                 = 1'b1;
            rf_we[k]                 = 1'b1;
            rf_waddr[k*RW +: RW]     = rd_q[i];
            rf_wdata[k*XLEN +: XLEN] = data_q[i];
          end
        end
        rank = rank + 1;
      end
    end
  end

  assign in_ready = ((pend_q & ~grant) == '0);
  assign busy     = |pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      retire_cnt <= '0;
      sel_err    <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else if (accept) begin
      pend_q     <= new_p;
      retire_cnt <= retire_cnt + 32'($countones(lane_en));
      sel_err    <= sel_err | (|rsvd);
      for (int i = 0; i < NUM_LANES; i++) begin
        data_q[i] <= mux_d[i];
        rd_q[i]   <= rd_addr[i*RW +: RW];
      end
    end else begin
      pend_q <= pend_q & ~grant;
    end
  end

endmodule

// File: tb/tb_wb_stage_multi.sv
// Directed bench for wb_stage_multi: two-port table vectors
// plus single-port stall and mid-drain reset sequences.
module tb_wb_stage_multi;

  logic        clk = 1'b0;
  logic        rst2, rst1, v2, v1;
  logic [1:0]  lane_en, reg_write;
  logic [3:0]  wb_sel;
  logic [9:0]  rd_addr;
  logic [63:0] aluout, read_data, pc_plus4;

  logic        rdy2, busy2, err2;
  logic [1:0]  we2;
  logic [9:0]  wa2;
  logic [63:0] wd2;
  logic [31:0] cnt2;

  logic        rdy1, busy1, err1;
  logic [0:0]  we1;
  logic [4:0]  wa1;
  logic [31:0] wd1;
  logic [31:0] cnt1;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  wb_stage_multi #(.NUM_WPORTS(2)) u2 (
    .clk(clk), .rst(rst2), .in_valid(v2), .in_ready(rdy2),
    .lane_en(lane_en), .reg_write(reg_write), .wb_sel(wb_sel),
    .rd_addr(rd_addr), .aluout(aluout), .read_data(read_data),
    .pc_plus4(pc_plus4), .rf_we(we2), .rf_waddr(wa2),
    .rf_wdata(wd2), .busy(busy2), .retire_cnt(cnt2),
    .sel_err(err2)
  );

  wb_stage_multi #(.NUM_WPORTS(1)) u1 (
    .clk(clk), .rst(rst1), .in_valid(v1), .in_ready(rdy1),
    .lane_en(lane_en), .reg_write(reg_write), .wb_sel(wb_sel),
    .rd_addr(rd_addr), .aluout(aluout), .read_data(read_data),
    .pc_plus4(pc_plus4), .rf_we(we1), .rf_waddr(wa1),
    .rf_wdata(wd1), .busy(busy1), .retire_cnt(cnt1),
    .sel_err(err1)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] en, input logic [1:0] rw,
                       input logic [3:0] sel, input logic [9:0] rd,
                       input logic [63:0] alu, input logic [63:0] rdat,
                       input logic [63:0] pc4);
    lane_en   = en;
    reg_write = rw;
    wb_sel    = sel;
    rd_addr   = rd;
    aluout    = alu;
    read_data = rdat;
    pc_plus4  = pc4;
  endtask

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  rw;
    logic [3:0]  sel;
    logic [9:0]  rd;
    logic [63:0] alu;
    logic [63:0] rdat;
    logic [63:0] pc4;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        err;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{2'b11, 2'b11, 4'b0100, {5'd4, 5'd3},
              {32'h0, 32'h11}, {32'h22, 32'h0}, 64'h0,
              2'b11, {5'd4, 5'd3}, {32'h22, 32'h11}, 1'b0};
    vt[1] = '{2'b11, 2'b11, 4'b0000, {5'd7, 5'd7},
              {32'hBB, 32'hAA}, 64'h0, 64'h0,
              2'b01, {5'd0, 5'd7}, {32'h0, 32'hBB}, 1'b0};
    vt[2] = '{2'b11, 2'b11, 4'b1000, {5'd1, 5'd0},
              {32'h0, 32'h55}, 64'h0, {32'h104, 32'h0},
              2'b01, {5'd0, 5'd1}, {32'h0, 32'h104}, 1'b0};
    vt[3] = '{2'b01, 2'b11, 4'b0001, {5'd9, 5'd9},
              {32'h5, 32'h6}, {32'h88, 32'h99}, 64'h0,
              2'b01, {5'd0, 5'd9}, {32'h0, 32'h99}, 1'b0};
    vt[4] = '{2'b11, 2'b00, 4'b0000, {5'd2, 5'd3},
              {32'h1, 32'h2}, 64'h0, 64'h0,
              2'b00, 10'd0, 64'h0, 1'b0};
    vt[5] = '{2'b10, 2'b11, 4'b0011, {5'd10, 5'd11},
              {32'h3C, 32'h4D}, 64'h0, 64'h0,
              2'b01, {5'd0, 5'd10}, {32'h0, 32'h3C}, 1'b0};
    vt[6] = '{2'b01, 2'b11, 4'b0011, {5'd12, 5'd2},
              {32'h9, 32'h77}, {32'h0, 32'h1}, {32'h0, 32'h2},
              2'b01, {5'd0, 5'd2}, {32'h0, 32'h77}, 1'b1};

    rst2 = 1'b1;
    rst1 = 1'b1;
    v2   = 1'b0;
    v1   = 1'b0;
    drive(2'b00, 2'b00, 4'b0, 10'd0, 64'h0, 64'h0, 64'h0);
    tick();
    tick();
    rst2 = 1'b0;
    rst1 = 1'b0;
    chk("rst_we2", 64'(we2), 64'h0);
    chk("rst_busy2", 64'(busy2), 64'h0);
    chk("rst_rdy2", 64'(rdy2), 64'h1);
    chk("rst_cnt2", 64'(cnt2), 64'h0);
    chk("rst_err2", 64'(err2), 64'h0);
    chk("rst_rdy1", 64'(rdy1), 64'h1);

    // Back-to-back bundles on the two-port instance.
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].en, vt[i].rw, vt[i].sel, vt[i].rd,
            vt[i].alu, vt[i].rdat, vt[i].pc4);
      v2 = 1'b1;
      exp_cnt += $countones(vt[i].en);
      tick();
      chk($sformatf("v%0d_we", i), 64'(we2), 64'(vt[i].we));
      chk($sformatf("v%0d_wa", i), 64'(wa2), 64'(vt[i].wa));
      chk($sformatf("v%0d_wd", i), wd2, vt[i].wd);
      chk($sformatf("v%0d_rdy", i), 64'(rdy2), 64'h1);
      chk($sformatf("v%0d_cnt", i), 64'(cnt2), 64'(exp_cnt));
      chk($sformatf("v%0d_err", i), 64'(err2), 64'(vt[i].err));
    end
    v2 = 1'b0;
    tick();
    chk("idle_we2", 64'(we2), 64'h0);
    chk("idle_busy2", 64'(busy2), 64'h0);
    chk("sticky_err2", 64'(err2), 64'h1);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    chk("clr_err2", 64'(err2), 64'h0);
    chk("clr_cnt2", 64'(cnt2), 64'h0);

    // Single port: two writes drain over two cycles with a held bundle.
    drive(2'b11, 2'b11, 4'b0000, {5'd6, 5'd5},
          {32'h2, 32'h1}, 64'h0, 64'h0);
    v1 = 1'b1;
    tick();
    drive(2'b11, 2'b01, 4'b0000, {5'd9, 5'd8},
          {32'h0, 32'h3}, 64'h0, 64'h0);
    chk("s1_we", 64'(we1), 64'h1);
    chk("s1_wa", 64'(wa1), 64'd5);
    chk("s1_wd", 64'(wd1), 64'h1);
    chk("s1_rdy", 64'(rdy1), 64'h0);
    chk("s1_busy", 64'(busy1), 64'h1);
    tick();
    chk("s2_we", 64'(we1), 64'h1);
    chk("s2_wa", 64'(wa1), 64'd6);
    chk("s2_wd", 64'(wd1), 64'h2);
    chk("s2_rdy", 64'(rdy1), 64'h1);
    chk("s2_cnt", 64'(cnt1), 64'd2);
    tick();
    v1 = 1'b0;
    chk("s3_we", 64'(we1), 64'h1);
    chk("s3_wa", 64'(wa1), 64'd8);
    chk("s3_wd", 64'(wd1), 64'h3);
    chk("s3_cnt", 64'(cnt1), 64'd4);
    tick();
    chk("s4_we", 64'(we1), 64'h0);
    chk("s4_busy", 64'(busy1), 64'h0);

    // Reset in the first drain cycle discards the second write.
    drive(2'b11, 2'b11, 4'b0000, {5'd6, 5'd5},
          {32'h2, 32'h1}, 64'h0, 64'h0);
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    chk("r0_wa", 64'(wa1), 64'd5);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk("r1_we", 64'(we1), 64'h0);
    chk("r1_busy", 64'(busy1), 64'h0);
    chk("r1_cnt", 64'(cnt1), 64'h0);
    chk("r1_rdy", 64'(rdy1), 64'h1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("r%0d_no_r6", c + 2), 64'(we1), 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
